// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the MEM-stage / debug data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    PIPE = 1'b0,
    DBG  = 1'b1
  } owner_t;

  localparam int unsigned MEM_LATENCY_DEF  = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ADDR_W           = 32;

  // Access captured at grant and replayed to memory for the whole BUSY window.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/mem_data_arb.sv
// Arbitrates the data memory between the MEM-stage pipeline and a debug/loader port.
// Optional alignment trap: define MEM_DATA_ARB_ALIGN_CHECK_EN.
module mem_data_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = MEM_LATENCY_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_mem_read,
  input  logic        pipe_mem_write,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        pipe_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        align_err
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  acc_t              acc_q, acc_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  logic pipe_req, dbg_win, pipe_win, busy;
  acc_t grant_acc;

  // Debug only beats a pending pipe request once the pipe has starved it long enough.
  assign pipe_req = pipe_mem_read | pipe_mem_write;
  assign dbg_win  = dbg_req & (~pipe_req | (starve_q == SW'(STARVE_LIMIT)));
  assign pipe_win = pipe_req & ~dbg_win;

  always_comb begin
    if (dbg_win) begin
      grant_acc.we    = dbg_we;
      grant_acc.addr  = dbg_addr;
      grant_acc.wdata = dbg_wdata;
    end else begin
      grant_acc.we    = pipe_mem_write;
      grant_acc.addr  = pipe_addr;
      grant_acc.wdata = pipe_wdata;
    end
  end

`ifdef MEM_DATA_ARB_ALIGN_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
`ifdef MEM_DATA_ARB_ALIGN_CHECK_EN
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (dbg_win || pipe_win) begin
          if (dbg_win) owner_d = DBG;
          else         owner_d = PIPE;
          acc_d = grant_acc;
          cnt_d = CNT_W'(MEM_LATENCY - 1);
`ifdef MEM_DATA_ARB_ALIGN_CHECK_EN
          if (|grant_acc.addr[1:0]) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (!grant_acc.we) rd_d = '0;
          end else
`endif
          state_d = BUSY;
        end
        if (dbg_win) begin
          starve_d = '0;
        end else if (pipe_win && dbg_req && (starve_q != SW'(STARVE_LIMIT))) begin
          starve_d = starve_q + SW'(1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!acc_q.we) rd_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!dbg_req) starve_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= PIPE;
      cnt_q    <= '0;
      starve_q <= '0;
      acc_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
    end
  end

`ifdef MEM_DATA_ARB_ALIGN_CHECK_EN
  // err_q is only ever set on the edge into DONE, so it is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign align_err = err_q;
`else
  assign align_err = 1'b0;
`endif

  assign busy       = (state_q == BUSY);
  assign mem_read   = busy & ~acc_q.we;
  assign mem_write  = busy & acc_q.we;
  assign mem_addr   = busy ? acc_q.addr  : '0;
  assign mem_wdata  = busy ? acc_q.wdata : '0;
  assign pipe_rdata = rd_q;
  assign dbg_rdata  = rd_q;
  assign dbg_ack    = (state_q == DONE) & (owner_q == DBG);

  // A pending pipe request in IDLE always stalls, whether it wins or loses.
  assign pipe_stall = rst_n & (((state_q == IDLE) & pipe_req) | (busy & (owner_q == PIPE)));

endmodule

// File: doc/mem_data_arb.md
MEM_DATA_ARB -- requirements
Module: mem_data_arb

Interface
REQ-001 Parameter MEM_LATENCY, default 2, data memory access cycles (legal range 1..15) SHALL be supported.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive pipeline grants allowed while debug waits SHALL be supported.
REQ-003 Ports SHALL be: clk in 1 system clock; rst_n in 1 synchronous active-low reset.
REQ-004 Ports SHALL be: pipe_mem_read in 1, pipe_mem_write in 1, pipe_addr in 32, pipe_wdata in 32, pipe_rdata out 32, pipe_stall out 1 (MEM-stage requester).
REQ-005 Ports SHALL be: dbg_req in 1, dbg_we in 1, dbg_addr in 32, dbg_wdata in 32, dbg_ack out 1, dbg_rdata out 32 (debug/loader requester).
REQ-006 Ports SHALL be: mem_read out 1, mem_write out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32 (to DataMemoryUnit); align_err out 1.
REQ-007 The block has one clock; reset is synchronous and active-low (clk, rst_n).

Function
REQ-008 FSM states SHALL be IDLE, BUSY, DONE; owner register SHALL record PIPE or DBG.
REQ-009 IDLE: pipe request = pipe_mem_read|pipe_mem_write; if only one requester pending, grant it; next state BUSY, latency counter loaded MEM_LATENCY-1.
REQ-010 Both pending in IDLE: pipeline SHALL win unless starve counter == STARVE_LIMIT, then debug wins.
REQ-011 Starve counter SHALL increment on each pipeline grant while dbg_req=1, clear on debug grant or when dbg_req=0, saturate at STARVE_LIMIT.
REQ-012 Address, write data and direction SHALL be latched at grant; mem_addr/mem_wdata driven from latches during BUSY.
REQ-013 BUSY: mem_read or mem_write SHALL be asserted every cycle for exactly MEM_LATENCY cycles; counter decrements; at 0 capture mem_rdata into read register and go DONE.
REQ-014 DONE: lasts one cycle, requests ignored, next state IDLE.
REQ-015 pipe_stall SHALL be 1 combinationally in IDLE when pipe request present and granted, 1 throughout BUSY for PIPE owner, 1 in IDLE while a pipe request loses arbitration, and 0 otherwise; total stall = MEM_LATENCY+1 cycles per pipeline access.
REQ-016 pipe_rdata SHALL hold the read register; valid in DONE for PIPE owner and held until the next capture.
REQ-017 dbg_ack SHALL pulse one cycle in DONE for DBG owner; dbg_rdata valid with it and held.
REQ-018 Debug requester holds dbg_req and fields stable until dbg_ack; dbg_req dropping mid-access SHALL not abort; ack still pulses.
REQ-019 Writes SHALL leave the read register unchanged.
REQ-020 Memory strobes SHALL be 0 in IDLE and DONE; never both 1.

Reset
REQ-021 On a clk edge with rst_n=0: state IDLE, owner PIPE, counters 0, read register 0, all outputs 0.
REQ-022 pipe_stall SHALL be forced 0 while rst_n=0.
REQ-023 Reset during BUSY SHALL abort the access: strobes 0 from the next cycle, no ack, no stall release glitch.

Configuration
REQ-024 Macro MEM_DATA_ARB_ALIGN_CHECK_EN defined: a granted access with addr[1:0]!=0 SHALL skip BUSY, go to DONE, pulse align_err one cycle, return rdata 0, issue no memory strobe.
REQ-025 Macro undefined: addresses passed unchanged, align_err tied 0, port retained.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/DONE), owner enum (PIPE/DBG) and MEM_LATENCY/STARVE_LIMIT defaults.
REQ-027 No sub-module SHALL be instantiated; DataMemoryUnit stays outside, connected at the MEM-stage level.

Verification
REQ-028 Pipe read addr 0x10, memory returns 0xDEADBEEF, MEM_LATENCY=2 -> stall 3 cycles, mem_read 2 cycles, pipe_rdata=0xDEADBEEF in DONE.
REQ-029 Pipe write addr 0x20 data 0x12345678 -> mem_write 2 cycles with those values, stall 3 cycles, pipe_rdata unchanged.
REQ-030 dbg_req held, pipe requesting continuously, STARVE_LIMIT=4 -> exactly 4 pipe grants, then debug granted, dbg_ack one pulse.
REQ-031 Simultaneous first requests, counter 0 -> pipe first, debug next; dbg_rdata valid with ack.
REQ-032 rst_n low in 2nd BUSY cycle -> strobes 0 next cycle, state IDLE, no ack, stall 0.
REQ-033 With MEM_DATA_ARB_ALIGN_CHECK_EN, pipe read addr 0x13 -> no mem_read, align_err 1 cycle, pipe_rdata 0, stall 1 cycle.
